spi_slave_rx: RTL and testbench
===============================

# spi_slave_rx

Receive-side SPI slave. Samples the `sclk`/`cs`/`mosi` lines driven by the upstream SPI master on the system clock. Deserialises MSB-first frames of `N` bits into parallel words and buffers them in a small FIFO. A downstream consumer drains the FIFO with a valid/ready handshake. Runs entirely in the `clk` domain; the SPI lines are treated as asynchronous inputs.

## Interface
- `N`, 8: word width in bits; a frame is N `sclk` rising edges while `cs` is low.
- `SYNC_STAGES`, 2: flip-flop stages on each of `sclk`, `cs` and `mosi`; minimum 2.
- `FIFO_DEPTH`, 4: receive FIFO entries; power of two, at least 2.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset; 0 clears all state immediately.
- `sclk`  in  1  SPI clock from the master; data is sampled on its rising edge.
- `cs`  in  1  chip select, active-low.
- `mosi`  in  1  serial data, MSB first.
- `out_data`  out  N  head-of-FIFO word; valid only while `out_valid`=1.
- `out_valid`  out  1  FIFO non-empty.
- `out_ready`  in  1  consumer accepts; a pop occurs when `out_valid` & `out_ready`.
- `overrun`  out  1  one-cycle pulse: a completed word was dropped because the FIFO was full.
- `frame_err`  out  1  one-cycle pulse: `cs` rose with a partial word (1..N-1 bits) captured.

## Operation
- Reset values: `out_data`=0, `out_valid`=0, `overrun`=0, `frame_err`=0. Synchronisers reset to `sclk`=0, `cs`=1, `mosi`=0. The shift register, bit count and FIFO pointers are cleared.
- All three SPI lines pass through `SYNC_STAGES` flops. One further delay flop on synced `sclk` and on synced `cs` provides edge detection. `mosi` uses the same delay depth, so data stays aligned with `sclk`.
- State machine, evaluated on synced `cs`:
  - IDLE: `cs`=1. `sclk` edges are ignored and the bit count is held at 0. A falling edge of `cs` moves to RECV.
  - RECV: on each synced `sclk` rising edge, `shreg <= {shreg[N-2:0], mosi_s}` and `cnt <= cnt+1`.
  - On the N-th edge, the word `{shreg[N-2:0], mosi_s}` is pushed to the FIFO and `cnt` wraps to 0. The block stays in RECV, so continuous streaming under one `cs` low yields consecutive words.
  - A rising edge of `cs` returns to IDLE. If `cnt`≠0, pulse `frame_err`, discard the partial word and clear `cnt`.
- Push while the FIFO is full and no pop occurs in that cycle: the word is dropped, `overrun` pulses, and FIFO contents are untouched.
- Push and pop in the same cycle while full: both take effect and there is no overrun. Push and pop in the same cycle while empty: the push lands and `out_valid` rises next cycle; there is no fall-through.
- `cs` rising in the same cycle as the N-th `sclk` edge: the word completes and is pushed, and `frame_err` stays 0.
- `cnt` width is $clog2(N)$ bits plus 1 if needed to hold N-1. FIFO pointers are $clog2(FIFO_DEPTH)$ bits plus one wrap bit. Full/empty are derived from pointer compare.
- Reset asserted mid-frame or mid-drain clears everything. After release, the first word begins at the next `cs` falling edge.

## Timing
- Input constraint: each `sclk` high and low phase, and `mosi` setup relative to the `sclk` rise, must last at least 2 `clk` periods. The upstream master meets this with 2-cycle phases.
- Latency: let edge k be the first `clk` edge that samples the N-th `sclk`=1 at the pin. With `SYNC_STAGES`=2, the push occurs at edge k+2 and `out_valid`/`out_data` are visible after edge k+2.
- `frame_err` pulses in the cycle after the `cs` rising edge is detected at synchroniser output, which is 3 edges after the pin change.
- `overrun` pulses in the cycle after the dropped push.
- Sustained throughput: 1 word per N `sclk` periods; the FIFO pops at up to 1 word per `clk`.

## Structure
- `spi_defs.vh`: state encodings (IDLE, RECV), default `N`, and the `SYNC_STAGES` minimum. Shared with the SPI master.
- Sub-module `sync_fifo` with parameters WIDTH and DEPTH, ports push/pop/full/empty, registered read. It is reusable for a future transmit-side buffer.
- The synchroniser and edge detect stay inline.

## Test plan
- Single frame: `cs` low, send 0xA5 MSB first with 2-clk phases, `cs` high. Required: `out_data`=0xA5, `out_valid` at edge k+2, `frame_err`=0.
- Streaming: one `cs` low period with 16 `sclk` edges carrying 0x3C then 0xC3. Required: two FIFO words in order, 0x3C then 0xC3.
- Overrun: `out_ready`=0, send frames 0x01..0x05. Required: FIFO holds 0x01..0x04, one `overrun` pulse on the 5th word, then a drain returns 0x01..0x04.
- Full with simultaneous pop: FIFO full, `out_ready`=1 in the push cycle. Required: no `overrun`, order preserved.
- Partial frame: 5 bits then `cs` high. Required: one `frame_err` pulse, no push. The next full frame 0x5A is received intact.
- Reset mid-frame: `reset`=0 after 3 bits. Required: all outputs 0 immediately. After release, frame 0xFF yields exactly 0xFF.

Source files
------------

// File: rtl/spi_slave_rx_pkg.sv
// spi_slave_rx_pkg: receiver state encoding and parameter defaults shared with the SPI master
package spi_slave_rx_pkg;
  typedef enum logic {IDLE, RECV} spi_state_e;
  localparam int SPI_N = 8;
  localparam int SYNC_MIN = 2;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered head-of-queue read and overflow-safe push
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wptr, rptr, rptr_nx;
  logic do_push, do_pop;
  assign full = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty = wptr == rptr;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rptr_nx = rptr + (AW+1)'(do_pop);
  always_ff @(posedge clk)
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  // rdata tracks the next head; a push into an effectively empty queue bypasses the array
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
      rdata <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      rptr <= rptr_nx;
      rdata <= (do_push && rptr_nx[AW-1:0] == wptr[AW-1:0]) ? wdata : mem[rptr_nx[AW-1:0]];
    end
endmodule

// File: rtl/spi_slave_rx.sv
// spi_slave_rx: SPI slave receiver, MSB-first N-bit words into a valid/ready FIFO
module spi_slave_rx
  import spi_slave_rx_pkg::*;
#(
  parameter int N = SPI_N,
  parameter int SYNC_STAGES = SYNC_MIN,
  parameter int FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         sclk,
  input  logic         cs,
  input  logic         mosi,
  output logic [N-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         overrun,
  output logic         frame_err
);
  localparam int SS = (SYNC_STAGES < SYNC_MIN) ? SYNC_MIN : SYNC_STAGES;
  localparam int CW = $clog2(N);
  logic [SS-1:0] sclk_q, cs_q, mosi_q;
  logic sclk_d, cs_d, mosi_d;
  logic sclk_rise, cs_fall, cs_rise;
  spi_state_e state, state_nx;
  logic [N-1:0] shreg, shreg_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic last, push, pop, full, empty, err_nx;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      sclk_q <= '0;
      cs_q <= '1;
      mosi_q <= '0;
      sclk_d <= 1'b0;
      cs_d <= 1'b1;
      mosi_d <= 1'b0;
    end else begin
      sclk_q <= {sclk_q[SS-2:0], sclk};
      cs_q <= {cs_q[SS-2:0], cs};
      mosi_q <= {mosi_q[SS-2:0], mosi};
      sclk_d <= sclk_q[SS-1];
      cs_d <= cs_q[SS-1];
      mosi_d <= mosi_q[SS-1];
    end
  assign sclk_rise = sclk_q[SS-1] && !sclk_d;
  assign cs_fall = cs_d && !cs_q[SS-1];
  assign cs_rise = !cs_d && cs_q[SS-1];
  // a word completing in the same cycle cs rises is still pushed and is not a framing error
  always_comb begin
    state_nx = state;
    shreg_nx = shreg;
    cnt_nx = cnt;
    push = 1'b0;
    err_nx = 1'b0;
    last = cnt == CW'(N-1);
    if (state == IDLE) begin
      cnt_nx = '0;
      if (cs_fall) state_nx = RECV;
    end else begin
      if (sclk_rise) begin
        shreg_nx = {shreg[N-2:0], mosi_d};
        cnt_nx = last ? '0 : cnt + 1'b1;
        push = last;
      end
      if (cs_rise) begin
        state_nx = IDLE;
        cnt_nx = '0;
        err_nx = (cnt != '0 || sclk_rise) && !push;
      end
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      shreg <= '0;
      cnt <= '0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state <= state_nx;
      shreg <= shreg_nx;
      cnt <= cnt_nx;
      frame_err <= err_nx;
      overrun <= push && full && !pop;
    end
  assign out_valid = !empty;
  assign pop = out_valid && out_ready;
  sync_fifo #(.WIDTH(N), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(pop),
    .wdata(shreg_nx),
    .rdata(out_data),
    .full(full),
    .empty(empty)
  );
endmodule

// File: tb/tb_spi_slave_rx.sv
// tb_spi_slave_rx: randomized and directed checks of spi_slave_rx against a word-level queue model
module tb_spi_slave_rx;
  localparam int N = 8;
  logic clk = 1'b0;
  logic reset, sclk, cs, mosi, out_ready;
  logic [N-1:0] out_data;
  logic out_valid, overrun, frame_err;
  int n_chk = 0, n_pass = 0;
  int ovr_cnt = 0, err_cnt = 0, exp_ovr = 0, exp_err = 0;
  logic [N-1:0] exp_q [$];

  spi_slave_rx dut (
    .clk(clk), .reset(reset), .sclk(sclk), .cs(cs), .mosi(mosi),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .overrun(overrun), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk)
    if (reset) begin
      if (overrun) ovr_cnt++;
      if (frame_err) err_cnt++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("pop_q_size", exp_q.size(), 1);
        else chk("pop_data", int'(out_data), int'(exp_q.pop_front()));
      end
    end

  task automatic shift(input logic [N-1:0] w, input int nb, input bit latchk, input bit popp);
    for (int i = 0; i < nb; i++) begin
      mosi = w[N-1-i];
      sclk = 1'b0;
      step(2);
      sclk = 1'b1;
      if (i == nb - 1 && (latchk || popp)) begin
        step(2);
        if (latchk) chk("lat_k1_valid", int'(out_valid), 0);
        if (popp) out_ready = 1'b1;
        step(1);
        if (latchk) begin
          chk("lat_k2_valid", int'(out_valid), 1);
          chk("lat_k2_data", int'(out_data), int'(w));
        end
        if (popp) out_ready = 1'b0;
      end else step(2);
    end
  endtask

  task automatic frame(input logic [N-1:0] w, input int nb, input bit keep, input bit latchk, input bit popp);
    if (keep && nb == N) exp_q.push_back(w);
    if (nb > 0 && nb < N) exp_err++;
    cs = 1'b0;
    step(3);
    shift(w, nb, latchk, popp);
    sclk = 1'b0;
    step(2);
    cs = 1'b1;
    step(4);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 100 && (exp_q.size() != 0 || out_valid); i++) step(1);
    chk("drain_left", exp_q.size(), 0);
    out_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b0; sclk = 1'b0; cs = 1'b1; mosi = 1'b0; out_ready = 1'b0;
    step(3);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_data", int'(out_data), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_frame_err", int'(frame_err), 0);
    reset = 1'b1;
    step(2);
    frame(8'hA5, N, 1, 1, 0);
    drain();
    chk("single_err", err_cnt, exp_err);
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hC3);
    cs = 1'b0;
    step(3);
    shift(8'h3C, N, 0, 0);
    shift(8'hC3, N, 0, 0);
    sclk = 1'b0;
    step(2);
    cs = 1'b1;
    step(4);
    chk("stream_depth_valid", int'(out_valid), 1);
    drain();
    for (int i = 1; i <= 5; i++) frame(8'(i), N, i <= 4, 0, 0);
    exp_ovr++;
    chk("ovr_pulses", ovr_cnt, exp_ovr);
    chk("ovr_head", int'(out_data), 1);
    drain();
    for (int i = 0; i < 4; i++) frame(8'h10 + 8'(i), N, 1, 0, 0);
    frame(8'h14, N, 1, 0, 1);
    chk("full_pop_ovr", ovr_cnt, exp_ovr);
    drain();
    frame(8'h00, 5, 1, 0, 0);
    chk("partial_err", err_cnt, exp_err);
    chk("partial_no_push", int'(out_valid), 0);
    frame(8'h5A, N, 1, 0, 0);
    drain();
    chk("partial_err_after", err_cnt, exp_err);
    frame(8'h77, N, 1, 0, 0);
    cs = 1'b0;
    step(3);
    shift(8'hFF, 3, 0, 0);
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_data", int'(out_data), 0);
    chk("mid_rst_overrun", int'(overrun), 0);
    chk("mid_rst_frame_err", int'(frame_err), 0);
    exp_q.delete();
    cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
    step(2);
    reset = 1'b1;
    step(3);
    frame(8'hFF, N, 1, 0, 0);
    drain();
    chk("post_rst_err", err_cnt, exp_err);
    for (int t = 0; t < 20; t++) begin
      logic [N-1:0] w;
      int nb;
      w = 8'($urandom);
      nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, N - 1)) : N;
      out_ready = 1'($urandom_range(0, 1));
      frame(w, nb, 1, 0, 0);
      out_ready = 1'b1;
      step(2);
    end
    drain();
    chk("rand_err", err_cnt, exp_err);
    chk("rand_ovr", ovr_cnt, exp_ovr);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
